// File: rtl/fb_write_if.sv
// Control-path to framebuffer port-A bundle for the write sequencer.
// The slave side is the sequencer; the master side is the control path / RAM / scan logic.
interface fb_write_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_frame_start;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  vblank;
    logic [ADDR_WIDTH-1:0] ram_a_address;
    logic [DATA_WIDTH-1:0] ram_a_data_in;
    logic                  ram_a_write_enable;
    logic                  ram_a_clk_enable;
    logic                  read_bank;
    logic                  write_bank;
    logic                  frame_done;
    logic                  frame_abort;

    modport master (
        output wr_frame_start, wr_data, wr_valid, vblank,
        input  wr_ready, ram_a_address, ram_a_data_in, ram_a_write_enable,
        input  ram_a_clk_enable, read_bank, write_bank, frame_done, frame_abort
    );

    modport slave (
        input  wr_frame_start, wr_data, wr_valid, vblank,
        output wr_ready, ram_a_address, ram_a_data_in, ram_a_write_enable,
        output ram_a_clk_enable, read_bank, write_bank, frame_done, frame_abort
    );
endinterface

// File: rtl/fb_write_sequencer.sv
// Fills the back bank of a double-buffered framebuffer byte by byte through RAM port A
// and swaps front/back banks on the first vblank after a complete frame.
module fb_write_sequencer #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_BYTES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    fb_write_if.slave   bus
);
    localparam int OFF_W = ADDR_WIDTH - 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_BYTES - 1);

    if (FRAME_BYTES < 1 || FRAME_BYTES > 2 ** (ADDR_WIDTH - 1)) begin : g_bad_frame_bytes
        $error("fb_write_sequencer: FRAME_BYTES must lie in 1..2**(ADDR_WIDTH-1)");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    state_t                state;
    logic [OFF_W-1:0]      offset;
    logic                  read_bank_q;
    logic                  write_bank_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  we_q;
    logic                  clk_en_q;
    logic                  done_q;
    logic                  abort_q;

    logic                  accept;
    logic [OFF_W-1:0]      wr_off;

    // A restart in FILL rewinds to offset 0 in the same cycle, so a byte arriving
    // alongside the restart lands at the start of the new frame.
    always_comb begin
        accept = bus.wr_valid && (state == FILL);
        wr_off = bus.wr_frame_start ? '0 : offset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            offset       <= '0;
            read_bank_q  <= 1'b0;
            write_bank_q <= 1'b1;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            clk_en_q     <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            clk_en_q <= 1'b1;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.wr_frame_start) begin
                        state  <= FILL;
                        offset <= '0;
                    end
                end

                FILL: begin
                    if (bus.wr_frame_start) begin
                        abort_q <= 1'b1;
                    end
                    if (accept) begin
                        addr_q <= {write_bank_q, wr_off};
                        data_q <= bus.wr_data;
                        we_q   <= 1'b1;
                        if (wr_off == LAST_OFF) begin
                            state  <= WAIT_SWAP;
                            offset <= '0;
                        end else begin
                            offset <= wr_off + OFF_W'(1);
                        end
                    end else begin
                        offset <= wr_off;
                    end
                end

                WAIT_SWAP: begin
                    // A lone frame_start here is dropped: the finished frame must be shown first.
                    if (bus.vblank) begin
                        read_bank_q  <= write_bank_q;
                        write_bank_q <= ~write_bank_q;
                        done_q       <= 1'b1;
                        offset       <= '0;
                        state        <= bus.wr_frame_start ? FILL : IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    offset <= '0;
                end
            endcase
        end
    end

    assign bus.wr_ready           = (state == FILL);
    assign bus.ram_a_address      = addr_q;
    assign bus.ram_a_data_in      = data_q;
    assign bus.ram_a_write_enable = we_q;
    assign bus.ram_a_clk_enable   = clk_en_q;
    assign bus.read_bank          = read_bank_q;
    assign bus.write_bank         = write_bank_q;
    assign bus.frame_done         = done_q;
    assign bus.frame_abort        = abort_q;
endmodule

// File: tb/tb_fb_write_sequencer.sv
// Directed bench for fb_write_sequencer with a 4-byte frame; port-A writes are
// checked against a queue of hand-computed {address, data} pairs by a negedge monitor.
module tb_fb_write_sequencer;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int FB = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    fb_write_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fb_write_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_BYTES(FB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Present one cycle of inputs, then return 1 ns after the edge that sampled them.
    task automatic step(input logic s, input logic v, input logic [DW-1:0] d, input logic vb);
        bus.wr_frame_start = s;
        bus.wr_valid       = v;
        bus.wr_data        = d;
        bus.vblank         = vb;
        @(posedge clk);
        #1;
        bus.wr_frame_start = 1'b0;
        bus.wr_valid       = 1'b0;
        bus.wr_data        = '0;
        bus.vblank         = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_read_bank"}, 32'(bus.read_bank), 0);
        chk({tag, "_write_bank"}, 32'(bus.write_bank), 1);
        chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 0);
        chk({tag, "_we"}, 32'(bus.ram_a_write_enable), 0);
        chk({tag, "_done"}, 32'(bus.frame_done), 0);
        chk({tag, "_abort"}, 32'(bus.frame_abort), 0);
        chk({tag, "_clk_en"}, 32'(bus.ram_a_clk_enable), 0);
        chk({tag, "_addr"}, 32'(bus.ram_a_address), 0);
        chk({tag, "_data"}, 32'(bus.ram_a_data_in), 0);
    endtask

    always @(negedge clk) begin
        if (bus.ram_a_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bus.ram_a_address, bus.ram_a_data_in);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(bus.ram_a_address), 32'(w.addr));
                chk("wr_data", 32'(bus.ram_a_data_in), 32'(w.data));
            end
        end
        if (reset === 1'b0) begin
            chk("banks_complementary", 32'(bus.read_bank ^ bus.write_bank), 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_frame_start = 1'b0;
        bus.wr_valid       = 1'b0;
        bus.wr_data        = '0;
        bus.vblank         = 1'b0;

        // Test 1: reset for two cycles
        reset = 1'b1;
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        chk_reset_state("rst1");
        reset = 1'b0;

        // IDLE ignores wr_valid and vblank; clock enable rises after the first free cycle
        step(0, 1, 8'hEE, 1);
        chk("clk_en_up", 32'(bus.ram_a_clk_enable), 1);
        chk("idle_ready", 32'(bus.wr_ready), 0);
        chk("idle_banks", 32'(bus.read_bank), 0);

        // Test 2/3: fill bank 1 with A..D, vblank during FILL is ignored
        step(1, 0, 8'h00, 0);
        chk("fill_ready", 32'(bus.wr_ready), 1);
        expect_wr(12'h800, "A");
        step(0, 1, "A", 0);
        chk("lat1_we", 32'(bus.ram_a_write_enable), 1);
        chk("lat1_addr", 32'(bus.ram_a_address), 32'h800);
        expect_wr(12'h801, "B");
        step(0, 1, "B", 0);
        step(0, 0, 8'h00, 1);
        chk("fill_vblank_rb", 32'(bus.read_bank), 0);
        chk("fill_vblank_done", 32'(bus.frame_done), 0);
        chk("fill_vblank_ready", 32'(bus.wr_ready), 1);
        expect_wr(12'h802, "C");
        step(0, 1, "C", 0);
        expect_wr(12'h803, "D");
        step(0, 1, "D", 0);
        chk("full_ready", 32'(bus.wr_ready), 0);

        // Lone frame_start in WAIT_SWAP is dropped
        step(1, 1, 8'h55, 0);
        chk("wait_start_ready", 32'(bus.wr_ready), 0);
        chk("wait_start_abort", 32'(bus.frame_abort), 0);

        step(0, 0, 8'h00, 1);
        chk("swap_rb", 32'(bus.read_bank), 1);
        chk("swap_wb", 32'(bus.write_bank), 0);
        chk("swap_done", 32'(bus.frame_done), 1);
        step(0, 0, 8'h00, 0);
        chk("done_pulse_end", 32'(bus.frame_done), 0);
        chk("after_swap_ready", 32'(bus.wr_ready), 0);

        // Test 4: gapped valid 1,0,0,1,1 into bank 0
        step(1, 0, 8'h00, 0);
        expect_wr(12'h000, 8'h10);
        step(0, 1, 8'h10, 0);
        step(0, 0, 8'h99, 0);
        chk("gap_we", 32'(bus.ram_a_write_enable), 0);
        chk("gap_addr_hold", 32'(bus.ram_a_address), 32'h000);
        chk("gap_data_hold", 32'(bus.ram_a_data_in), 32'h10);
        step(0, 0, 8'h98, 0);
        chk("gap2_we", 32'(bus.ram_a_write_enable), 0);
        expect_wr(12'h001, 8'h11);
        step(0, 1, 8'h11, 0);
        expect_wr(12'h002, 8'h12);
        step(0, 1, 8'h12, 0);
        chk("gap_still_fill", 32'(bus.wr_ready), 1);

        // Test 5: restarts inside FILL
        step(1, 0, 8'h00, 0);
        chk("abort1", 32'(bus.frame_abort), 1);
        expect_wr(12'h000, 8'h20);
        step(0, 1, 8'h20, 0);
        chk("abort1_end", 32'(bus.frame_abort), 0);
        expect_wr(12'h001, 8'h21);
        step(0, 1, 8'h21, 0);
        step(1, 0, 8'h00, 0);
        chk("abort2", 32'(bus.frame_abort), 1);
        chk("abort2_we", 32'(bus.ram_a_write_enable), 0);
        expect_wr(12'h000, 8'h30);
        step(0, 1, 8'h30, 0);
        chk("restart_addr", 32'(bus.ram_a_address), 32'h000);
        expect_wr(12'h000, 8'h40);
        step(1, 1, 8'h40, 0);
        chk("abort3", 32'(bus.frame_abort), 1);
        chk("abort3_we", 32'(bus.ram_a_write_enable), 1);
        expect_wr(12'h001, 8'h41);
        step(0, 1, 8'h41, 0);
        expect_wr(12'h002, 8'h42);
        step(0, 1, 8'h42, 0);
        expect_wr(12'h003, 8'h43);
        step(0, 1, 8'h43, 0);
        chk("full2_ready", 32'(bus.wr_ready), 0);

        // Test 6: frame_start with vblank swaps and goes straight back to FILL
        step(1, 0, 8'h00, 1);
        chk("sw2_rb", 32'(bus.read_bank), 0);
        chk("sw2_wb", 32'(bus.write_bank), 1);
        chk("sw2_done", 32'(bus.frame_done), 1);
        chk("sw2_ready", 32'(bus.wr_ready), 1);
        chk("sw2_abort", 32'(bus.frame_abort), 0);
        expect_wr(12'h800, "Z");
        step(0, 1, "Z", 0);
        chk("z_addr", 32'(bus.ram_a_address), 32'h800);

        // Reset mid-FILL wins over a simultaneous valid byte
        reset = 1'b1;
        step(0, 1, "Y", 0);
        step(0, 0, 8'h00, 0);
        chk_reset_state("rst2");
        reset = 1'b0;
        step(0, 0, 8'h00, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
